// File: rtl/uart_reg_bridge.sv
// UART-side register bridge: parses 'W' addr data / 'R' addr commands from the RX FIFO,
// drives a single-cycle register bus and returns ACK, read data or NAK through the TX FIFO.
module uart_reg_bridge #(
    parameter int unsigned     dbit    = 8,
    parameter int unsigned     timeout = 65535,
    parameter logic [dbit-1:0] CMD_WR  = 8'h57,
    parameter logic [dbit-1:0] CMD_RD  = 8'h52,
    parameter logic [dbit-1:0] ACK     = 8'h06,
    parameter logic [dbit-1:0] NAK     = 8'h15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_empty,
    input  logic [dbit-1:0] rx_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [dbit-1:0] tx_data,
    output logic [dbit-1:0] reg_addr,
    output logic [dbit-1:0] reg_wdata,
    output logic            reg_we,
    output logic            reg_re,
    input  logic [dbit-1:0] reg_rdata,
    output logic            busy,
    output logic            err_tmo
);

    localparam int unsigned CW = $clog2(timeout);
    localparam logic [CW-1:0] TMO_LAST = CW'(timeout - 1);

    typedef enum logic [2:0] {
        StIdle, StGetAddr, StGetData, StSettle, StBusWr, StBusRd, StRdWait, StSend
    } state_t;

    state_t        state;
    state_t        ret;
    logic          is_wr;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ret       <= StIdle;
            is_wr     <= 1'b0;
            tmo_cnt   <= '0;
            rx_rd     <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            rx_rd   <= 1'b0;
            tx_wr   <= 1'b0;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            err_tmo <= 1'b0;
            unique case (state)
                StIdle: begin
                    tmo_cnt <= '0;
                    if (!rx_empty) begin
                        rx_rd <= 1'b1;
                        busy  <= 1'b1;
                        state <= StSettle;
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            is_wr <= (rx_data == CMD_WR);
                            ret   <= StGetAddr;
                        end else begin
                            tx_data <= NAK;
                            ret     <= StSend;
                        end
                    end
                end
                StGetAddr, StGetData: begin
                    if (!rx_empty) begin
                        rx_rd   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= StSettle;
                        if (state == StGetAddr) begin
                            reg_addr <= rx_data;
                            ret      <= is_wr ? StGetData : StBusRd;
                        end else begin
                            reg_wdata <= rx_data;
                            ret       <= StBusWr;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort the partial command silently apart from the error pulse.
                        err_tmo <= 1'b1;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StSettle: begin
                    // Strobes are launched here so they are high for exactly the bus state.
                    state  <= ret;
                    reg_we <= (ret == StBusWr);
                    reg_re <= (ret == StBusRd);
                end
                StBusWr: begin
                    tx_data <= ACK;
                    state   <= StSend;
                end
                StBusRd: state <= StRdWait;
                StRdWait: begin
                    tx_data <= reg_rdata;
                    state   <= StSend;
                end
                StSend: begin
                    if (!tx_full) begin
                        tx_wr   <= 1'b1;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: directed commands, expected bus/TX events queued by the
// stimulus and consumed by a negedge monitor that also models the show-ahead RX FIFO.
module tb_uart_reg_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_tmo;

    always #5 clk = ~clk;

    uart_reg_bridge #(
        .dbit    (8),
        .timeout (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rx_rd     (rx_rd),
        .tx_full   (tx_full),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_tmo   (err_tmo)
    );

    typedef struct {
        logic [7:0] b;
        int         lat;  // rx_rd-to-tx_wr cycles, negative = not checked
    } tx_exp_t;

    logic [7:0]  rx_q[$];
    tx_exp_t     exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_re[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop = 0;
    int pop_cnt = 0;
    int tx_cnt = 0;
    int tmo_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and RX FIFO model.
    always @(negedge clk) begin
        if (rx_rd) begin
            last_pop = cyc;
            pop_cnt++;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
        end
        if (tx_wr) begin
            tx_cnt++;
            if (exp_tx.size() == 0) begin
                chk("unexpected_tx_wr", {24'h0, tx_data}, 32'hffff_ffff);
            end else begin
                tx_exp_t e;
                e = exp_tx.pop_front();
                chk("tx_data", {24'h0, tx_data}, {24'h0, e.b});
                if (e.lat >= 0) chk("tx_latency", cyc - last_pop, e.lat);
            end
        end
        if (reg_we) begin
            if (exp_wr.size() == 0) chk("unexpected_reg_we", {16'h0, reg_addr, reg_wdata}, 32'hffff_ffff);
            else chk("reg_write", {16'h0, reg_addr, reg_wdata}, {16'h0, exp_wr.pop_front()});
        end
        if (reg_re) begin
            if (exp_re.size() == 0) chk("unexpected_reg_re", {24'h0, reg_addr}, 32'hffff_ffff);
            else chk("reg_read_addr", {24'h0, reg_addr}, {24'h0, exp_re.pop_front()});
        end
        if (reg_we && reg_re) chk("we_re_exclusive", 32'd1, 32'd0);
        if (err_tmo) tmo_pulses++;
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {rx_rd, tx_wr, reg_we, reg_re, busy, err_tmo, tx_data, reg_addr, reg_wdata}, 32'd0);
    endtask

    int p0, t0, e0;

    initial begin
        rst       = 1'b1;
        rx_empty  = 1'b1;
        rx_data   = 8'h00;
        tx_full   = 1'b0;
        reg_rdata = 8'h00;
        tick(3);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick(2);

        // 1: back-to-back write
        exp_wr.push_back(16'h10A5);
        exp_tx.push_back('{8'h06, 3});
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5);
        tick(20);
        chk("t1_reg_addr_held", {24'h0, reg_addr}, 32'h10);
        chk("t1_busy_idle", {31'h0, busy}, 32'd0);

        // 2: read, exactly two pops
        p0 = pop_cnt;
        reg_rdata = 8'h3C;
        exp_re.push_back(8'h22);
        exp_tx.push_back('{8'h3C, 4});
        rx_q.push_back(8'h52); rx_q.push_back(8'h22);
        tick(20);
        chk("t2_pop_count", pop_cnt - p0, 2);

        // 3: bad opcode gives NAK, then a normal write
        exp_tx.push_back('{8'h15, 2});
        exp_wr.push_back(16'h0102);
        exp_tx.push_back('{8'h06, 3});
        rx_q.push_back(8'h41); rx_q.push_back(8'h57); rx_q.push_back(8'h01); rx_q.push_back(8'h02);
        tick(25);
        chk("t3_pop_count", pop_cnt - p0, 6);

        // 4: timeout in GET_DATA, then a read is served
        e0 = tmo_pulses;
        t0 = tx_cnt;
        rx_q.push_back(8'h57); rx_q.push_back(8'h05);
        tick(50);
        chk("t4_busy_waiting", {31'h0, busy}, 32'd1);
        chk("t4_no_early_tmo", tmo_pulses - e0, 0);
        tick(70);
        chk("t4_tmo_pulse", tmo_pulses - e0, 1);
        chk("t4_busy_after_tmo", {31'h0, busy}, 32'd0);
        chk("t4_no_tx", tx_cnt - t0, 0);
        reg_rdata = 8'h5A;
        exp_re.push_back(8'h05);
        exp_tx.push_back('{8'h5A, 4});
        rx_q.push_back(8'h52); rx_q.push_back(8'h05);
        tick(20);
        chk("t4_read_after_tmo", tx_cnt - t0, 1);

        // 5: TX back-pressure holds SEND and blocks further pops
        tx_full = 1'b1;
        t0 = tx_cnt;
        reg_rdata = 8'hC3;
        exp_wr.push_back(16'h3344);
        exp_tx.push_back('{8'h06, -1});
        exp_re.push_back(8'h66);
        exp_tx.push_back('{8'hC3, 4});
        rx_q.push_back(8'h57); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        rx_q.push_back(8'h52); rx_q.push_back(8'h66);
        tick(60);
        chk("t5_no_tx_while_full", tx_cnt - t0, 0);
        chk("t5_no_pop_while_full", rx_q.size(), 2);
        chk("t5_busy_while_full", {31'h0, busy}, 32'd1);
        tx_full = 1'b0;
        tick(20);
        chk("t5_tx_after_release", tx_cnt - t0, 2);

        // 6: reset in GET_DATA discards the partial command
        t0 = tx_cnt;
        rx_q.push_back(8'h57); rx_q.push_back(8'h77);
        tick(8);
        chk("t6_busy_before_rst", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk_all_zero("t6_rst_outputs");
        rst = 1'b0;
        tick(1);
        chk_all_zero("t6_after_rst_outputs");
        exp_wr.push_back(16'h0A0B);
        exp_tx.push_back('{8'h06, 3});
        rx_q.push_back(8'h57); rx_q.push_back(8'h0A); rx_q.push_back(8'h0B);
        tick(20);
        chk("t6_one_tx", tx_cnt - t0, 1);

        chk("end_tx_queue_empty", exp_tx.size(), 0);
        chk("end_wr_queue_empty", exp_wr.size(), 0);
        chk("end_re_queue_empty", exp_re.size(), 0);
        chk("end_rx_drained", rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
